// File: rtl/regfile_param_if.sv
// Register-file bus: two read ports, one write port, bulk-clear control
// and clear status. The master drives addresses, write data and requests;
// the slave (the register file) returns read data and BUSY/DONE.
interface regfile_param_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic [AW-1:0]    AA;
    logic [AW-1:0]    BA;
    logic [AW-1:0]    DA;
    logic [WIDTH-1:0] DD;
    logic             RW;
    logic             CLR;
    logic [WIDTH-1:0] AD;
    logic [WIDTH-1:0] BD;
    logic             BUSY;
    logic             DONE;

    modport master (
        output AA, BA, DA, DD, RW, CLR,
        input  AD, BD, BUSY, DONE
    );

    modport slave (
        input  AA, BA, DA, DD, RW, CLR,
        output AD, BD, BUSY, DONE
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one
// synchronous write port, optional write-through bypass, optional
// hard-wired-zero R0 and a one-entry-per-cycle bulk-clear engine.
module regfile_param #(
    parameter int WIDTH   = 16,
    parameter int AW      = 3,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0
) (
    input logic            CLK,
    input logic            RESET,
    regfile_param_if.slave bus
);
    localparam int          DEPTH = 2 ** AW;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                        state;
    logic [AW-1:0]                 ptr;
    logic                          busy_q;
    logic                          done_q;
    logic [DEPTH-1:0][WIDTH-1:0]   rf;
    logic [DEPTH-1:0]              wr_hit;
    logic [DEPTH-1:0]              clr_hit;
    logic                          wr_req;
    logic                          byp_en;

    // A write only takes effect in IDLE and loses to a simultaneous clear.
    assign wr_req = (state == IDLE) && bus.RW && !bus.CLR;
    assign byp_en = (BYPASS != 0) && wr_req;

    // Per-entry strobes: clear engine hit, or accepted write to this entry.
    always_comb begin
        wr_hit  = '0;
        clr_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            clr_hit[i] = (state == CLEAR) && (ptr == AW'(i));
            wr_hit[i]  = wr_req && (bus.DA == AW'(i)) &&
                         !((R0_ZERO != 0) && (i == 0));
        end
    end

    // Storage array; clear engine has priority over the write port.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rf <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_hit[i])
                    rf[i] <= '0;
                else if (wr_hit[i])
                    rf[i] <= bus.DD;
            end
        end
    end

    // Clear sequencer. CLR is ignored mid-clear, but if it is still high on
    // the edge that clears the last entry a new sweep begins straight away,
    // so that cycle shows DONE together with BUSY.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            ptr    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.CLR) begin
                        state  <= CLEAR;
                        ptr    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        done_q <= 1'b1;
                        if (!bus.CLR) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read port A: array, then write-through bypass, then R0 override.
    always_comb begin
        bus.AD = rf[bus.AA];
        if (byp_en && (bus.AA == bus.DA))
            bus.AD = bus.DD;
        if ((R0_ZERO != 0) && (bus.AA == '0))
            bus.AD = '0;
    end

    // Read port B: same priority as port A.
    always_comb begin
        bus.BD = rf[bus.BA];
        if (byp_en && (bus.BA == bus.DA))
            bus.BD = bus.DD;
        if ((R0_ZERO != 0) && (bus.BA == '0))
            bus.BD = '0;
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations driven in lockstep
// (bypass, no bypass, bypass + zero R0) against an array-based model.
`timescale 1ns/100ps
module tb_regfile_param;
    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [2:0]  aa, ba, da;
    logic [15:0] dd;
    logic        rw, clr;

    int vectors     = 0;
    int miscompares = 0;

    // model state
    logic [15:0] mem [3][DEPTH];
    int          clr_left;     // entries still to clear; 0 = idle
    logic        m_done;

    int busy_cnt, done_cnt;

    regfile_param_if #(.WIDTH(16), .AW(3)) b0();
    regfile_param_if #(.WIDTH(16), .AW(3)) b1();
    regfile_param_if #(.WIDTH(16), .AW(3)) b2();

    assign b0.AA = aa; assign b0.BA = ba; assign b0.DA = da;
    assign b0.DD = dd; assign b0.RW = rw; assign b0.CLR = clr;
    assign b1.AA = aa; assign b1.BA = ba; assign b1.DA = da;
    assign b1.DD = dd; assign b1.RW = rw; assign b1.CLR = clr;
    assign b2.AA = aa; assign b2.BA = ba; assign b2.DA = da;
    assign b2.DD = dd; assign b2.RW = rw; assign b2.CLR = clr;

    regfile_param #(.WIDTH(16), .AW(3), .BYPASS(1), .R0_ZERO(0))
        u0 (.CLK(CLK), .RESET(RESET), .bus(b0.slave));
    regfile_param #(.WIDTH(16), .AW(3), .BYPASS(0), .R0_ZERO(0))
        u1 (.CLK(CLK), .RESET(RESET), .bus(b1.slave));
    regfile_param #(.WIDTH(16), .AW(3), .BYPASS(1), .R0_ZERO(1))
        u2 (.CLK(CLK), .RESET(RESET), .bus(b2.slave));

    always #10 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Expected read value for config c at address a, given current inputs.
    function automatic logic [15:0] exp_rd(input int c, input logic [2:0] a);
        if (c == 2 && a == 3'd0) return 16'h0;
        if (c != 1 && clr_left == 0 && rw && !clr && a == da) return dd;
        return mem[c][a];
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < DEPTH; i++) mem[c][i] = 16'h0;
        clr_left = 0;
        m_done   = 1'b0;
    endfunction

    // What one rising edge does, given the inputs currently applied.
    function automatic void model_edge();
        m_done = 1'b0;
        if (clr_left > 0) begin
            for (int c = 0; c < 3; c++) mem[c][DEPTH - clr_left] = 16'h0;
            clr_left--;
            if (clr_left == 0) begin
                m_done = 1'b1;
                if (clr) clr_left = DEPTH;
            end
        end else if (clr) begin
            clr_left = DEPTH;
        end else if (rw) begin
            for (int c = 0; c < 3; c++)
                if (!(c == 2 && da == 3'd0)) mem[c][da] = dd;
        end
    endfunction

    task automatic chk_reads(input string tag);
        chk({tag, "_u0_AD"}, b0.AD, exp_rd(0, aa));
        chk({tag, "_u0_BD"}, b0.BD, exp_rd(0, ba));
        chk({tag, "_u1_AD"}, b1.AD, exp_rd(1, aa));
        chk({tag, "_u1_BD"}, b1.BD, exp_rd(1, ba));
        chk({tag, "_u2_AD"}, b2.AD, exp_rd(2, aa));
        chk({tag, "_u2_BD"}, b2.BD, exp_rd(2, ba));
    endtask

    task automatic chk_status(input string tag);
        logic eb;
        eb = (clr_left > 0);
        chk({tag, "_u0_BUSY"}, {15'h0, b0.BUSY}, {15'h0, eb});
        chk({tag, "_u0_DONE"}, {15'h0, b0.DONE}, {15'h0, m_done});
        chk({tag, "_u1_BUSY"}, {15'h0, b1.BUSY}, {15'h0, eb});
        chk({tag, "_u1_DONE"}, {15'h0, b1.DONE}, {15'h0, m_done});
        chk({tag, "_u2_BUSY"}, {15'h0, b2.BUSY}, {15'h0, eb});
        chk({tag, "_u2_DONE"}, {15'h0, b2.DONE}, {15'h0, m_done});
    endtask

    // One clock: drive in the low phase, check reads, step model, check status.
    task automatic cyc(input logic [2:0] a_i, input logic [2:0] b_i, input logic [2:0] d_i,
                       input logic [15:0] dd_i, input logic rw_i, input logic clr_i,
                       input bit sweep);
        @(negedge CLK);
        aa = a_i; ba = b_i; da = d_i; dd = dd_i; rw = rw_i; clr = clr_i;
        #1 chk_reads("rd");
        if (sweep) begin
            for (int k = 0; k < DEPTH; k++) begin
                aa = 3'(k); ba = 3'(DEPTH - 1 - k);
                #1 chk_reads("sweep");
            end
            aa = a_i; ba = b_i;
        end
        model_edge();
        @(posedge CLK);
        #1 chk_status("st");
        if (b0.BUSY) busy_cnt++;
        if (b0.DONE) done_cnt++;
    endtask

    initial begin
        aa = '0; ba = '0; da = '0; dd = '0; rw = 1'b0; clr = 1'b0;
        RESET = 1'b1;
        model_reset();
        #1 RESET = 1'b0;
        #3;
        chk("rst_busy", {15'h0, b0.BUSY}, 16'h0);
        chk("rst_done", {15'h0, b0.DONE}, 16'h0);
        chk_reads("rst");
        @(negedge CLK);
        RESET = 1'b1;

        // 1: write R3, read it back; R2 still zero
        cyc(3'd0, 3'd0, 3'd3, 16'hA5A5, 1'b1, 1'b0, 1'b0);
        cyc(3'd3, 3'd2, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("t1_AD", b0.AD, 16'hA5A5);
        chk("t1_BD", b0.BD, 16'h0000);

        // 2: same-cycle bypass vs none
        cyc(3'd5, 3'd5, 3'd5, 16'h1234, 1'b1, 1'b0, 1'b0);
        cyc(3'd5, 3'd5, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("t2_nobyp_after", b1.AD, 16'h1234);

        // 3: R0 hard-wired zero
        cyc(3'd0, 3'd0, 3'd0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        cyc(3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("t3_r0zero", b2.AD, 16'h0000);
        chk("t3_r0plain", b0.AD, 16'hFFFF);

        // 4: fill, clear, write during BUSY dropped
        for (int i = 0; i < DEPTH; i++)
            cyc(3'(i), 3'(i), 3'(i), 16'(i + 1), 1'b1, 1'b0, 1'b0);
        busy_cnt = 0; done_cnt = 0;
        cyc(3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b1);
        for (int j = 0; j < DEPTH; j++)
            cyc(3'd7, 3'd0, 3'd7, 16'hBEEF, 1'b1, 1'b0, 1'b1);
        cyc(3'd7, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("t4_busy_cycles", 16'(busy_cnt), 16'd8);
        chk("t4_done_pulses", 16'(done_cnt), 16'd1);
        chk("t4_r7", b0.AD, 16'h0000);

        // 5: CLR beats RW in the same IDLE edge
        cyc(3'd1, 3'd1, 3'd1, 16'h7777, 1'b1, 1'b0, 1'b0);
        cyc(3'd1, 3'd1, 3'd1, 16'h00FF, 1'b1, 1'b1, 1'b0);
        chk("t5_busy", {15'h0, b0.BUSY}, 16'h1);
        for (int j = 0; j < DEPTH; j++)
            cyc(3'd1, 3'd1, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("t5_r1", b0.AD, 16'h0000);
        chk("t5_idle", {15'h0, b0.BUSY}, 16'h0);

        // CLR held high: restart on the final edge, DONE and BUSY together
        for (int j = 0; j < DEPTH + 1; j++)
            cyc(3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("hold_busy", {15'h0, b0.BUSY}, 16'h1);
        chk("hold_done", {15'h0, b0.DONE}, 16'h1);
        for (int j = 0; j < DEPTH; j++)
            cyc(3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("hold_end_busy", {15'h0, b0.BUSY}, 16'h0);

        // 6: reset in the middle of a clear
        for (int i = 0; i < DEPTH; i++)
            cyc(3'(i), 3'(i), 3'(i), 16'hC000 + 16'(i), 1'b1, 1'b0, 1'b0);
        cyc(3'd6, 3'd7, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        cyc(3'd6, 3'd7, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        cyc(3'd6, 3'd7, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        #2 RESET = 1'b0;
        model_reset();
        #1;
        chk("t6_busy", {15'h0, b0.BUSY}, 16'h0);
        chk("t6_done", {15'h0, b0.DONE}, 16'h0);
        chk("t6_r6", b0.AD, 16'h0000);
        chk("t6_r7", b0.BD, 16'h0000);
        @(negedge CLK);
        RESET = 1'b1;
        cyc(3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1);
        cyc(3'd0, 3'd0, 3'd4, 16'hAAAA, 1'b1, 1'b0, 1'b0);
        cyc(3'd4, 3'd4, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("t6_after", b1.AD, 16'hAAAA);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            cyc(3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
